// File: rtl/jump_charge_ctl.sv
// Charge-and-release jump controller: turns sampled key levels into walk and jump commands.
// Every decision is taken on frame_tick; registered outputs show up the cycle after the tick.
module jump_charge_ctl #(
    parameter int unsigned MAX_CHARGE = 60,
    parameter int unsigned PWR_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             key_space,
    input  logic             key_right,
    input  logic             key_left,
    input  logic             on_ground,
    output logic [1:0]       walk_dir,
    output logic             jump_start,
    output logic [PWR_W-1:0] jump_power,
    output logic [1:0]       jump_dir,
    output logic             charging
);

    typedef enum logic [1:0] {IDLE, CHARGE, AIR} state_t;

    localparam logic [PWR_W-1:0] MAX_CNT = PWR_W'(MAX_CHARGE);
    localparam logic [PWR_W-1:0] ONE_CNT = PWR_W'(1);

    state_t           state_q, state_d;
    logic [PWR_W-1:0] charge_cnt_q, charge_cnt_d;
    logic             space_prev_q, space_prev_d;
    logic             seen_low_q, seen_low_d;
    logic [1:0]       walk_dir_q, walk_dir_d;
    logic             jump_start_q, jump_start_d;
    logic [PWR_W-1:0] jump_power_q, jump_power_d;
    logic [1:0]       jump_dir_q, jump_dir_d;

    logic [1:0]       key_dir;
    logic             press;
    logic [PWR_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            charge_cnt_q <= '0;
            space_prev_q <= 1'b0;
            seen_low_q   <= 1'b0;
            walk_dir_q   <= '0;
            jump_start_q <= 1'b0;
            jump_power_q <= '0;
            jump_dir_q   <= '0;
        end else begin
            state_q      <= state_d;
            charge_cnt_q <= charge_cnt_d;
            space_prev_q <= space_prev_d;
            seen_low_q   <= seen_low_d;
            walk_dir_q   <= walk_dir_d;
            jump_start_q <= jump_start_d;
            jump_power_q <= jump_power_d;
            jump_dir_q   <= jump_dir_d;
        end
    end

    always_comb begin
        key_dir = 2'b00;
        if (key_right && !key_left) key_dir = 2'b01;
        if (key_left && !key_right) key_dir = 2'b10;
        press   = key_space && !space_prev_q;
        cnt_inc = charge_cnt_q + ONE_CNT;

        state_d      = state_q;
        charge_cnt_d = charge_cnt_q;
        space_prev_d = space_prev_q;
        seen_low_d   = seen_low_q;
        walk_dir_d   = walk_dir_q;
        jump_start_d = 1'b0;
        jump_power_d = jump_power_q;
        jump_dir_d   = jump_dir_q;

        if (frame_tick) begin
            space_prev_d = key_space;
            unique case (state_q)
                IDLE: begin
                    if (!on_ground) begin
                        state_d    = AIR;
                        seen_low_d = 1'b1;
                        walk_dir_d = 2'b00;
                    end else if (press) begin
                        state_d      = CHARGE;
                        charge_cnt_d = ONE_CNT;
                        walk_dir_d   = 2'b00;
                    end else begin
                        walk_dir_d = key_dir;
                    end
                end
                CHARGE: begin
                    walk_dir_d = 2'b00;
                    if (!on_ground) begin
                        state_d      = AIR;
                        charge_cnt_d = '0;
                        seen_low_d   = 1'b1;
                    end else if (!key_space || cnt_inc == MAX_CNT) begin
                        // Release launches with the count so far; hitting the cap launches at MAX.
                        state_d      = AIR;
                        jump_start_d = 1'b1;
                        jump_power_d = key_space ? MAX_CNT : charge_cnt_q;
                        jump_dir_d   = key_dir;
                        charge_cnt_d = '0;
                        seen_low_d   = 1'b0;
                    end else begin
                        charge_cnt_d = cnt_inc;
                    end
                end
                AIR: begin
                    walk_dir_d = 2'b00;
                    if (!on_ground) begin
                        seen_low_d = 1'b1;
                    end else if (seen_low_q) begin
                        state_d    = IDLE;
                        seen_low_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        walk_dir   = walk_dir_q;
        jump_start = jump_start_q;
        jump_power = jump_power_q;
        jump_dir   = jump_dir_q;
        charging   = (state_q == CHARGE);
    end

endmodule

// File: tb/tb_jump_charge_ctl.sv
// Randomised and directed checks of jump_charge_ctl against a tick-level behavioural model.
module tb_jump_charge_ctl;

    localparam int MAXC = 60;
    localparam int PW   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          key_space = 1'b0, key_right = 1'b0, key_left = 1'b0, on_ground = 1'b1;
    logic [1:0]    walk_dir, jump_dir;
    logic          jump_start, charging;
    logic [PW-1:0] jump_power;

    int errors = 0;
    int checks = 0;

    // Model: m_cnt > 0 means a charge is in progress; m_air means airborne.
    bit m_air, m_seen, m_prev, m_js;
    int m_cnt, m_walk, m_pwr, m_dir;
    logic o_js_tick, o_js_after;

    jump_charge_ctl #(.MAX_CHARGE(MAXC), .PWR_W(PW)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .key_space(key_space), .key_right(key_right), .key_left(key_left),
        .on_ground(on_ground), .walk_dir(walk_dir), .jump_start(jump_start),
        .jump_power(jump_power), .jump_dir(jump_dir), .charging(charging)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    function automatic int kdir(bit r, bit l);
        if (r && !l) return 1;
        if (l && !r) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_air = 0; m_seen = 0; m_prev = 0; m_js = 0;
        m_cnt = 0; m_walk = 0; m_pwr = 0; m_dir = 0;
    endtask

    task automatic model_tick(bit sp, bit r, bit l, bit g);
        int k = kdir(r, l);
        bit fire = 0;
        int fire_pwr = 0;
        m_js = 0;
        if (m_air) begin
            m_walk = 0;
            if (!g) m_seen = 1;
            else if (m_seen) begin m_air = 0; m_seen = 0; end
        end else if (m_cnt > 0) begin
            m_walk = 0;
            if (!g) begin m_cnt = 0; m_air = 1; m_seen = 1; end
            else if (!sp) begin fire = 1; fire_pwr = m_cnt; end
            else if (m_cnt + 1 >= MAXC) begin fire = 1; fire_pwr = MAXC; end
            else m_cnt++;
        end else begin
            if (!g) begin m_air = 1; m_seen = 1; m_walk = 0; end
            else if (sp && !m_prev) begin m_cnt = 1; m_walk = 0; end
            else m_walk = k;
        end
        if (fire) begin
            m_js = 1; m_pwr = fire_pwr; m_dir = k;
            m_cnt = 0; m_seen = 0; m_air = 1;
        end
        m_prev = sp;
    endtask

    // One frame: tick cycle, then one quiet cycle to confirm the pulse drops and outputs hold.
    task automatic step(bit sp, bit r, bit l, bit g);
        key_space = sp; key_right = r; key_left = l; on_ground = g;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        o_js_tick = jump_start;
        model_tick(sp, r, l, g);
        frame_tick = 1'b0;
        @(posedge clk); #1;
        o_js_after = jump_start;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_tick = 1'b0;
        key_space = 1'b0; key_right = 1'b0; key_left = 1'b0; on_ground = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({walk_dir, jump_start, jump_power, jump_dir, charging} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {walk_dir, jump_start, jump_power, jump_dir, charging});
        end
    endtask

    task automatic test_walk();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1);
            checks++;
            if (walk_dir !== 2'b01) begin errors++; $display("FAIL walk_right[%0d]: got %b required 01", i, walk_dir); end
        end
        step(0, 1, 1, 1);
        checks++;
        if (walk_dir !== 2'b00) begin errors++; $display("FAIL walk_both: got %b required 00", walk_dir); end
        step(0, 0, 1, 1);
        checks++;
        if (walk_dir !== 2'b10) begin errors++; $display("FAIL walk_left: got %b required 10", walk_dir); end
        step(0, 0, 0, 1);
        checks++;
        if (walk_dir !== 2'b00) begin errors++; $display("FAIL walk_none: got %b required 00", walk_dir); end
    endtask

    task automatic test_short_jump();
        do_reset();
        step(1, 0, 0, 1);
        checks++;
        if (charging !== 1'b1 || o_js_tick !== 1'b0) begin
            errors++; $display("FAIL short_press: got charging=%b js=%b required 1 0", charging, o_js_tick);
        end
        step(0, 0, 1, 1);
        checks++;
        if ({o_js_tick, o_js_after, jump_power, jump_dir, charging} !== {1'b1, 1'b0, PW'(1), 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL short_launch: got js=%b/%b pwr=%0d dir=%b chg=%b required 1/0 1 10 0",
                     o_js_tick, o_js_after, jump_power, jump_dir, charging);
        end
        step(0, 1, 0, 1);
        checks++;
        if (walk_dir !== 2'b00) begin errors++; $display("FAIL short_air_walk: got %b required 00", walk_dir); end
    endtask

    task automatic test_auto_launch();
        int pulses = 0;
        int at = 0;
        bit recharged = 0;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            step(1, 0, 0, 1);
            if (o_js_tick) begin pulses++; at = i; end
            if (o_js_after) pulses++;
            if (i > 60 && charging) recharged = 1;
        end
        checks++;
        if (pulses != 1 || at != MAXC) begin
            errors++; $display("FAIL auto_launch: got pulses=%0d at tick %0d required 1 at %0d", pulses, at, MAXC);
        end
        checks++;
        if (jump_power !== PW'(MAXC) || recharged) begin
            errors++; $display("FAIL auto_power: got pwr=%0d recharge=%0d required %0d 0", jump_power, recharged, MAXC);
        end
    endtask

    task automatic test_landing();
        do_reset();
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (o_js_tick !== 1'b1 || jump_dir !== 2'b01) begin
            errors++; $display("FAIL land_launch: got js=%b dir=%b required 1 01", o_js_tick, jump_dir);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        checks++;
        if (charging !== 1'b0 || walk_dir !== 2'b01) begin
            errors++; $display("FAIL land_no_charge: got chg=%b walk=%b required 0 01", charging, walk_dir);
        end
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        checks++;
        if (charging !== 1'b1) begin errors++; $display("FAIL land_repress: got chg=%b required 1", charging); end
    endtask

    task automatic test_reset_mid_charge();
        int js_seen = 0;
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, 0, 0, 1);
        key_space = 1'b1; frame_tick = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        js_seen += int'(jump_start);
        checks++;
        if ({walk_dir, jump_start, jump_power, jump_dir, charging} !== '0) begin
            errors++; $display("FAIL reset_mid_charge: got %b required 0",
                               {walk_dir, jump_start, jump_power, jump_dir, charging});
        end
        rst = 1'b0; frame_tick = 1'b0; key_space = 1'b0;
        model_reset();
        @(posedge clk); #1;
        js_seen += int'(jump_start);
        step(0, 1, 0, 1);
        js_seen += int'(o_js_tick);
        checks++;
        if (js_seen != 0 || walk_dir !== 2'b01) begin
            errors++; $display("FAIL reset_then_idle: got js=%0d walk=%b required 0 01", js_seen, walk_dir);
        end
    endtask

    task automatic test_ledge();
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 0);
        checks++;
        if (charging !== 1'b0 || o_js_tick !== 1'b0 || walk_dir !== 2'b00) begin
            errors++; $display("FAIL charge_abort: got chg=%b js=%b walk=%b required 0 0 00", charging, o_js_tick, walk_dir);
        end
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (walk_dir !== 2'b01) begin errors++; $display("FAIL abort_land_walk: got %b required 01", walk_dir); end
        step(0, 1, 0, 0);
        checks++;
        if (walk_dir !== 2'b00) begin errors++; $display("FAIL ledge_air: got %b required 00", walk_dir); end
        step(0, 1, 0, 1);
        checks++;
        if (walk_dir !== 2'b00) begin errors++; $display("FAIL ledge_land_tick: got %b required 00", walk_dir); end
        step(0, 1, 0, 1);
        checks++;
        if (walk_dir !== 2'b01) begin errors++; $display("FAIL ledge_idle: got %b required 01", walk_dir); end
    endtask

    task automatic test_random();
        bit sp = 0;
        logic [PW+6:0] exp_v, got_v;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                sp = 0;
            end
            if ($urandom_range(0, 5) == 0) sp = !sp;
            step(sp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
            exp_v = {2'(m_walk), 2'(m_dir), PW'(m_pwr), m_cnt > 0, m_js, 1'b0};
            got_v = {walk_dir, jump_dir, jump_power, charging, o_js_tick, o_js_after};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random[%0d]: got %b required %b", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_short_jump();
        test_auto_launch();
        test_landing();
        test_reset_mid_charge();
        test_ledge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
